// File: rtl/load_store_unit.sv
// Load/store master for a word-addressed data memory; sub-word stores use read-modify-write.
// Optional macro ACCESS_TIMEOUT_EN faults any memory wait longer than TIMEOUT_CYCLES.
module load_store_unit #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_fault,
   output logic [31:0] mem_in_addr,
   output logic [31:0] mem_in_data,
   output logic        mem_in_valid,
   input  logic        mem_in_ready,
   output logic [31:0] mem_out_addr,
   output logic        mem_out_valid,
   input  logic        mem_out_ready,
   input  logic [31:0] mem_out_data,
   input  logic        mem_addr_error
);

   typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, RESP} state_t;

   state_t      state;
   logic        write_q;
   logic [1:0]  size_q;
   logic        signed_q;
   logic [1:0]  ofs_q;
   logic [15:0] wdata_q;
   logic [31:0] word_q;
   logic        misaligned;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

`ifdef ACCESS_TIMEOUT_EN
   logic [31:0] wait_cnt;
`endif

   assign misaligned = (req_size == 2'd3) ||
                       (req_size == 2'd1 && req_addr[0]) ||
                       (req_size == 2'd2 && req_addr[1:0] != 2'b00);

   function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                           input logic [1:0] ofs, input logic sgn);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{ofs, 3'b000} +: 8];
      h = word[{ofs[1], 4'b0000} +: 16];
      case (size)
         2'd0:    return {{24{sgn & b[7]}}, b};
         2'd1:    return {{16{sgn & h[15]}}, h};
         default: return word;
      endcase
   endfunction

   // Only the addressed lane(s) change; the rest of the word is what memory returned.
   function automatic logic [31:0] merge(input logic [31:0] word, input logic [1:0] size,
                                         input logic [1:0] ofs, input logic [15:0] wd);
      logic [31:0] r;
      r = word;
      if (size == 2'd0) r[{ofs, 3'b000} +: 8] = wd[7:0];
      else              r[{ofs[1], 4'b0000} +: 16] = wd;
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         req_ready     <= 1'b1;
         resp_valid    <= 1'b0;
         resp_rdata    <= '0;
         resp_fault    <= 1'b0;
         mem_in_addr   <= '0;
         mem_in_data   <= '0;
         mem_in_valid  <= 1'b0;
         mem_out_addr  <= '0;
         mem_out_valid <= 1'b0;
         write_q       <= 1'b0;
         size_q        <= '0;
         signed_q      <= 1'b0;
         ofs_q         <= '0;
         wdata_q       <= '0;
         word_q        <= '0;
`ifdef ACCESS_TIMEOUT_EN
         wait_cnt      <= '0;
`endif
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               req_ready <= 1'b0;
               write_q   <= req_write;
               size_q    <= req_size;
               signed_q  <= req_signed;
               ofs_q     <= req_addr[1:0];
               wdata_q   <= req_wdata[15:0];
`ifdef ACCESS_TIMEOUT_EN
               wait_cnt  <= '0;
`endif
               if (misaligned) begin
                  resp_valid <= 1'b1;
                  resp_fault <= 1'b1;
                  resp_rdata <= '0;
                  state      <= RESP;
               end else begin
                  mem_in_addr  <= {req_addr[31:2], 2'b00};
                  mem_out_addr <= {req_addr[31:2], 2'b00};
                  if (req_write && req_size == 2'd2) begin
                     mem_in_data  <= req_wdata;
                     mem_in_valid <= 1'b1;
                     state        <= WRITE;
                  end else begin
                     mem_out_valid <= 1'b1;
                     state         <= READ;
                  end
               end
            end
            READ: if (mem_out_ready) begin
               mem_out_valid <= 1'b0;
               if (mem_addr_error) begin
                  resp_valid <= 1'b1;
                  resp_fault <= 1'b1;
                  resp_rdata <= '0;
                  state      <= RESP;
               end else if (!write_q) begin
                  resp_valid <= 1'b1;
                  resp_rdata <= extract(mem_out_data, size_q, ofs_q, signed_q);
                  state      <= RESP;
               end else begin
                  word_q <= mem_out_data;
                  state  <= MERGE;
               end
            end
`ifdef ACCESS_TIMEOUT_EN
            else if (wait_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
               mem_out_valid <= 1'b0;
               resp_valid    <= 1'b1;
               resp_fault    <= 1'b1;
               resp_rdata    <= '0;
               state         <= RESP;
            end else wait_cnt <= wait_cnt + 32'd1;
`endif
            MERGE: begin
               mem_in_data  <= merge(word_q, size_q, ofs_q, wdata_q);
               mem_in_valid <= 1'b1;
`ifdef ACCESS_TIMEOUT_EN
               wait_cnt     <= '0;
`endif
               state        <= WRITE;
            end
            WRITE: if (mem_in_ready) begin
               mem_in_valid <= 1'b0;
               resp_valid   <= 1'b1;
               resp_fault   <= mem_addr_error;
               resp_rdata   <= '0;
               state        <= RESP;
            end
`ifdef ACCESS_TIMEOUT_EN
            else if (wait_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
               mem_in_valid <= 1'b0;
               resp_valid   <= 1'b1;
               resp_fault   <= 1'b1;
               resp_rdata   <= '0;
               state        <= RESP;
            end else wait_cnt <= wait_cnt + 32'd1;
`endif
            RESP: begin
               resp_valid <= 1'b0;
               resp_fault <= 1'b0;
               resp_rdata <= '0;
               req_ready  <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: a stalling 128-byte memory plus a byte-array reference model.
module tb_load_store_unit;

   logic        clk = 1'b0, reset = 1'b1;
   logic        req_valid = 1'b0, req_ready, req_write = 1'b0, req_signed = 1'b0;
   logic [1:0]  req_size = '0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        resp_valid, resp_fault;
   logic [31:0] resp_rdata;
   logic [31:0] mem_in_addr, mem_in_data, mem_out_addr;
   logic        mem_in_valid, mem_out_valid;
   logic        mem_in_ready = 1'b0, mem_out_ready = 1'b0, mem_addr_error = 1'b0;
   logic [31:0] mem_out_data = '0;

   load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
      .mem_in_addr(mem_in_addr), .mem_in_data(mem_in_data), .mem_in_valid(mem_in_valid),
      .mem_in_ready(mem_in_ready), .mem_out_addr(mem_out_addr), .mem_out_valid(mem_out_valid),
      .mem_out_ready(mem_out_ready), .mem_out_data(mem_out_data), .mem_addr_error(mem_addr_error));

   always #5 clk = ~clk;

   int tests = 0, fails = 0;
   logic [31:0] sim_mem [32];
   logic [7:0]  ref_mem [128];
   int  stall_fixed = 0;
   bit  mem_dead = 1'b0;
   int  in_cycles = 0;
   bit  active = 1'b0;
   int  cnt = 0;
   logic [31:0] hold_a, hold_d;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Memory: ready after a stall; out-of-range (>= 128 bytes) reports addr_error.
   always @(negedge clk) begin
      logic [31:0] a;
      logic err;
      check("valid_excl", 32'(mem_in_valid & mem_out_valid), 32'd0);
      if (mem_in_valid) in_cycles++;
      if ((mem_out_valid || mem_in_valid) && !reset) begin
         a = mem_in_valid ? mem_in_addr : mem_out_addr;
         if (!active) begin
            active = 1'b1;
            cnt = (stall_fixed >= 0) ? stall_fixed : int'($urandom_range(0, 3));
            hold_a = a;
            hold_d = mem_in_data;
         end else begin
            check("addr_stable", a, hold_a);
            if (mem_in_valid) check("data_stable", mem_in_data, hold_d);
         end
         if (cnt == 0 && !mem_dead) begin
            err = (a >= 32'd128);
            mem_addr_error = err;
            if (mem_out_valid) begin
               mem_out_ready = 1'b1;
               mem_out_data = err ? $urandom : sim_mem[a[6:2]];
            end else begin
               mem_in_ready = 1'b1;
               if (!err) sim_mem[a[6:2]] = mem_in_data;
            end
         end else begin
            if (cnt > 0) cnt--;
            mem_out_ready = 1'b0;
            mem_in_ready = 1'b0;
            mem_addr_error = 1'b0;
         end
      end else begin
         active = 1'b0;
         mem_out_ready = 1'b0;
         mem_in_ready = 1'b0;
         mem_addr_error = 1'b0;
      end
   end

   // Reference: byte-addressed little-endian memory, updated per request.
   task automatic model(input bit w, input logic [1:0] sz, input bit sg, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] erd, output logic ef);
      int n;
      logic [31:0] v;
      n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      erd = 32'd0;
      ef = (sz == 2'd3) || (a % n != 0);
      if (!ef) ef = mem_dead || (a >= 32'd128);
      if (ef) return;
      if (w) begin
         for (int i = 0; i < n; i++) ref_mem[a + i] = wd[8*i +: 8];
      end else begin
         v = 32'd0;
         for (int i = 0; i < n; i++) v = v | (32'(ref_mem[a + i]) << (8*i));
         if (sg && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
         erd = v;
      end
   endtask

   task automatic do_req(input bit w, input logic [1:0] sz, input bit sg, input logic [31:0] a,
                         input logic [31:0] wd, input int exp_lat,
                         output logic [31:0] rd, output logic flt);
      logic [31:0] erd;
      logic ef;
      int n;
      bit got;
      model(w, sz, sg, a, wd, erd, ef);
      @(negedge clk);
      check("idle_ready", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
      req_addr = a; req_wdata = wd;
      @(posedge clk);
      #1 req_valid = 1'b0;
      n = 0; got = 1'b0;
      while (!got && n < 300) begin
         @(negedge clk);
         n++;
         if (resp_valid) got = 1'b1;
      end
      check("resp_seen", 32'(got), 32'd1);
      rd = resp_rdata;
      flt = resp_fault;
      check("resp_fault", 32'(flt), 32'(ef));
      check("resp_rdata", rd, erd);
      if (exp_lat >= 0) check("latency", 32'(n), 32'(exp_lat));
      @(negedge clk);
      check("one_pulse", 32'(resp_valid), 32'd0);
   endtask

   initial begin
      logic [31:0] rd, a;
      logic flt;
      int ic;
      bit w;
      logic [1:0] sz;
      for (int i = 0; i < 32; i++) begin
         sim_mem[i] = $urandom;
         for (int k = 0; k < 4; k++) ref_mem[4*i + k] = sim_mem[i][8*k +: 8];
      end
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_out_valid", 32'(mem_out_valid), 32'd0);
      check("rst_in_valid", 32'(mem_in_valid), 32'd0);
      check("rst_in_addr", mem_in_addr, 32'd0);
      reset = 1'b0;

      do_req(1, 2'd2, 0, 32'h24, 32'hefefefef, 2, rd, flt);
      check("mem9_word", sim_mem[9], 32'hefefefef);
      do_req(0, 2'd2, 1, 32'h24, 32'h0, 2, rd, flt);
      check("word_load", rd, 32'hefefefef);
      do_req(1, 2'd2, 0, 32'h24, 32'h11223344, 2, rd, flt);
      do_req(1, 2'd0, 0, 32'h27, 32'h000000A5, 4, rd, flt);
      check("mem9_byte", sim_mem[9], 32'hA5223344);
      do_req(0, 2'd0, 1, 32'h27, 32'h0, 2, rd, flt);
      check("sbyte_load", rd, 32'hFFFFFFA5);
      do_req(0, 2'd0, 0, 32'h27, 32'h0, 2, rd, flt);
      check("ubyte_load", rd, 32'h000000A5);
      do_req(1, 2'd2, 0, 32'h24, 32'h80001234, 2, rd, flt);
      do_req(0, 2'd1, 1, 32'h26, 32'h0, 2, rd, flt);
      check("shalf_load", rd, 32'hFFFF8000);
      do_req(0, 2'd1, 0, 32'h26, 32'h0, 2, rd, flt);
      check("uhalf_load", rd, 32'h00008000);
      ic = in_cycles;
      do_req(1, 2'd2, 0, 32'h22, 32'h5555AAAA, 1, rd, flt);
      check("misalign_no_write", 32'(in_cycles), 32'(ic));
      do_req(0, 2'd3, 0, 32'h20, 32'h0, 1, rd, flt);

      stall_fixed = 5;
      do_req(0, 2'd2, 0, 32'h24, 32'h0, 7, rd, flt);
      do_req(1, 2'd1, 0, 32'h12, 32'h0000BEEF, -1, rd, flt);
      stall_fixed = 0;
      do_req(0, 2'd2, 0, 32'h80, 32'h0, 2, rd, flt);
      ic = in_cycles;
      do_req(1, 2'd0, 0, 32'h80, 32'h77, 2, rd, flt);
      check("oor_no_write", 32'(in_cycles), 32'(ic));

      // Reset during a stalled write: the store must vanish with no response.
      stall_fixed = 1000;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("wr_wait_valid", 32'(mem_in_valid), 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("rst_mid_in_valid", 32'(mem_in_valid), 32'd0);
      check("rst_mid_req_ready", 32'(req_ready), 32'd1);
      check("rst_mid_resp", 32'(resp_valid), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      stall_fixed = -1;

`ifdef ACCESS_TIMEOUT_EN
      mem_dead = 1'b1;
      do_req(0, 2'd2, 0, 32'h10, 32'h0, 9, rd, flt);
      mem_dead = 1'b0;
`endif

      for (int t = 0; t < 80; t++) begin
         w = 1'($urandom_range(0, 1));
         sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         a = 32'($urandom_range(0, 143));
         if ($urandom_range(0, 2) != 0) a = a & ~((32'd1 << sz) - 32'd1);
         do_req(w, sz, 1'($urandom_range(0, 1)), a, $urandom, -1, rd, flt);
      end

      for (int i = 0; i < 32; i++)
         check("final_mem", sim_mem[i], {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator-side master for the word-addressed data memory.
- Accepts one load/store request at a time from the core, with byte, halfword or word size.
- Drives the memory write port (in_*) and read port (out_*) with the memory's valid/ready handshake.
- Returns a single-cycle response with extracted/extended load data or a fault.
- Sub-word stores are done as read-modify-write, because the memory only writes whole words.

Parameters:
- TIMEOUT_CYCLES, 64: maximum wait for memory ready before fault (used only with ACCESS_TIMEOUT_EN).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  core request present
- req_ready  output  1  unit idle, request accepted on this edge when req_valid=1
- req_write  input  1  1=store, 0=load
- req_size  input  2  0=byte, 1=halfword, 2=word; 3 is illegal
- req_signed  input  1  sign-extend load result
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- resp_valid  output  1  one-cycle response pulse
- resp_rdata  output  32  load result; 0 for stores and faults
- resp_fault  output  1  misaligned, illegal size, memory addr_error or timeout
- mem_in_addr  output  32  write address, word aligned
- mem_in_data  output  32  write data
- mem_in_valid  output  1  write request
- mem_in_ready  input  1  write complete
- mem_out_addr  output  32  read address, word aligned
- mem_out_valid  output  1  read request
- mem_out_ready  input  1  read complete
- mem_out_data  input  32  read data, valid while mem_out_ready=1
- mem_addr_error  input  1  out-of-range address, sampled with the ready signal

Behaviour:
- Reset (sync, active-high): state=IDLE. All outputs 0 except req_ready=1. Addresses and data are 0. Reset asserted mid-access forces IDLE on that edge; any pending response is dropped.
- States: IDLE, READ, MERGE, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch all req_* fields.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size=3 -> RESP with fault; no memory access.
  - Load -> READ. Word store -> WRITE. Sub-word store -> READ.
- Word address: mem_*_addr = {latched_addr[31:2],2'b00}.
- Byte lanes are little-endian: byte k occupies bits 8k+7:8k.
- READ:
  - mem_out_valid=1; address held stable.
  - Wait for mem_out_ready=1; on that edge capture mem_out_data and mem_addr_error.
  - addr_error -> RESP with fault; no write is issued, even for a store.
  - Load -> RESP. Sub-word store -> MERGE.
- MERGE:
  - One cycle.
  - Replace the addressed lane(s) of the captured word with req_wdata[7:0] or [15:0].
  - -> WRITE.
- WRITE:
  - mem_in_valid=1; mem_in_data = word data or merged data, held stable.
  - Wait for mem_in_ready=1; on that edge capture mem_addr_error.
  - -> RESP.
- RESP:
  - resp_valid=1 for exactly one cycle; all mem_*_valid=0; -> IDLE.
  - Because of this state, valid is always low the cycle after ready, so the memory never sees back-to-back reuse of one request.
- Load data: extract the lane; zero-extend, or sign-extend when req_signed=1. Word loads ignore req_signed.
- Latency:
  - Word load with memory ready on the first valid cycle: accept at edge T, READ in T..T+1, resp_valid in cycle T+2.
  - Sub-word store adds MERGE plus the WRITE handshake.
- mem_in_valid and mem_out_valid are never high together.
- req_ready=0 in every state except IDLE.
- Ready seen while not requesting is ignored.

Optional Feature:
- Macro: ACCESS_TIMEOUT_EN.
- Defined:
  - A counter clears on entering READ or WRITE and increments each waiting cycle.
  - When it reaches TIMEOUT_CYCLES without ready: drop valid, go to RESP with resp_fault=1 and resp_rdata=0.
- Undefined: no counter; READ and WRITE wait indefinitely.

Test Plan:
- Word store: addr 0x24, data 0xefefefef, then word load 0x24 -> memory word 9 = 0xefefefef; load resp_rdata=0xefefefef, fault=0; exactly one resp_valid pulse per request.
- Byte store: 0xA5 to addr 0x27 over word 0x11223344 -> READ, MERGE, WRITE sequence; memory word = 0xA5223344. Signed byte load 0x27 -> 0xFFFFFFA5; unsigned -> 0x000000A5.
- Halfword load at 0x26 of 0x80001234 -> signed 0xFFFF8000, unsigned 0x00008000. Word store at 0x22 -> fault, mem valids never asserted, resp_valid 1 cycle after accept.
- Memory stalls ready 5 cycles -> address/data stable throughout, resp 1 cycle after ready. Load at 0x80 on 128-byte memory -> resp_fault=1. Sub-word store at 0x80 -> no mem_in_valid.
- Reset asserted during WRITE wait -> next edge mem_in_valid=0, req_ready=1, no resp_valid.
- With ACCESS_TIMEOUT_EN and TIMEOUT_CYCLES=8, memory never ready -> resp_fault after 8 wait cycles, unit back in IDLE.
